// File: rtl/memory_stage.sv
// Pipeline MEM stage: load/store over a req/ack memory port, registers MEM/WB state.
// Latency: 1 cycle MEM->W for non-memory ops and zero-wait accesses, k extra cycles for k ack waits.
// Backpressure: stall_mem holds upstream while an access waits for ack; aborts after TIMEOUT-1 waits.
module memory_stage #(
   parameter int DW      = 22,
   parameter int RW      = 4,
   parameter int TIMEOUT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_m,
   input  logic [DW-1:0] alu_result_m,
   input  logic [DW-1:0] write_data_m,
   input  logic [RW-1:0] write_reg_m,
   input  logic          reg_write_m,
   input  logic          mem_write_m,
   input  logic          mem_to_reg_m,
   input  logic          pc_src_m,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] alu_result_memory,
   output logic          stall_mem,
   output logic          valid_w,
   output logic          reg_write_w,
   output logic          mem_to_reg_w,
   output logic          pc_src_w,
   output logic [DW-1:0] alu_result_w,
   output logic [DW-1:0] read_data_w,
   output logic [RW-1:0] write_reg_w,
   output logic          mem_error
);

   // Wait counter is at least 8 bits, wider if TIMEOUT needs it.
   localparam int CW = (($clog2(TIMEOUT) + 1) > 8) ? ($clog2(TIMEOUT) + 1) : 8;
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;

   logic          w_mem_op;
   logic          w_req;
   logic          w_ack;
   logic          w_abort;
   logic          w_stall;
   logic [DW-1:0] w_rdata_cap;

   // Request, completion, abort and stall decode for the current cycle.
   always_comb begin
      w_mem_op = valid_m & (mem_write_m | mem_to_reg_m);
      // BUSY keeps requesting; upstream is holding the same instruction in MEM.
      w_req    = ~rst & ((r_state == S_BUSY) | w_mem_op);
      w_ack    = w_req & mem_ack;
      // Ack on the last allowed wait cycle still wins over the abort.
      w_abort  = w_req & ~mem_ack & (r_state == S_BUSY) & (r_cnt == C_LAST);
      w_stall  = w_req & ~mem_ack & ~w_abort;
      // Loads return memory data; stores, aborts and non-memory ops record zero.
      w_rdata_cap = (w_ack & mem_to_reg_m & ~mem_write_m) ? mem_rdata : '0;
   end

   assign mem_req           = w_req;
   assign mem_we            = mem_write_m;
   assign mem_addr          = alu_result_m;
   assign mem_wdata         = write_data_m;
   assign alu_result_memory = alu_result_m;
   assign stall_mem         = w_stall;

   // Access FSM: IDLE until a request misses its same-cycle ack, BUSY while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_stall) begin
                  r_state <= S_BUSY;
                  r_cnt   <= CW'(1);
               end
            end
            S_BUSY: begin
               if (w_stall) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled or MEM empty, otherwise capture the instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_w      <= 1'b0;
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
         pc_src_w     <= 1'b0;
         alu_result_w <= '0;
         read_data_w  <= '0;
         write_reg_w  <= '0;
      end else if (w_stall | ~valid_m) begin
         valid_w     <= 1'b0;
         reg_write_w <= 1'b0;
         pc_src_w    <= 1'b0;
      end else begin
         valid_w      <= 1'b1;
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
         pc_src_w     <= pc_src_m;
         alu_result_w <= alu_result_m;
         read_data_w  <= w_rdata_cap;
         write_reg_w  <= write_reg_m;
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_error <= 1'b0;
      end else if (w_abort) begin
         mem_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus a randomized run
// checked against a transaction-level model (stall = min(k, TIMEOUT-1)).
module tb_memory_stage;

   localparam int DW = 22;
   localparam int RW = 4;
   localparam int TO = 8;

   logic          clk, rst;
   logic          valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m;
   logic [DW-1:0] alu_result_m, write_data_m, mem_rdata;
   logic [RW-1:0] write_reg_m;
   logic          mem_ack;
   logic          mem_req, mem_we, stall_mem;
   logic [DW-1:0] mem_addr, mem_wdata, alu_result_memory;
   logic          valid_w, reg_write_w, mem_to_reg_w, pc_src_w, mem_error;
   logic [DW-1:0] alu_result_w, read_data_w;
   logic [RW-1:0] write_reg_w;

   int tests = 0;
   int fails = 0;

   memory_stage #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid_m(valid_m), .alu_result_m(alu_result_m),
      .write_data_m(write_data_m), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
      .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m), .pc_src_m(pc_src_m),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_result_memory(alu_result_memory),
      .stall_mem(stall_mem), .valid_w(valid_w), .reg_write_w(reg_write_w),
      .mem_to_reg_w(mem_to_reg_w), .pc_src_w(pc_src_w), .alu_result_w(alu_result_w),
      .read_data_w(read_data_w), .write_reg_w(write_reg_w), .mem_error(mem_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one instruction into MEM (starting just after a rising edge), answers
   // with ack on wait cycle k (k<0: never), and returns at edge+1 after it retires.
   task automatic do_op(input logic v, input logic rw, input logic mw, input logic m2r,
                        input logic pc, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [RW-1:0] wr, input int k, input logic [DW-1:0] rd,
                        output int stalls, output int reqs, output int ncyc,
                        output bit stable, output bit bub_ok, output logic req0,
                        output logic we0);
      bit done;
      stalls = 0; reqs = 0; ncyc = 0; stable = 1; bub_ok = 1; req0 = 0; we0 = 0;
      valid_m = v; reg_write_m = rw; mem_write_m = mw; mem_to_reg_m = m2r; pc_src_m = pc;
      alu_result_m = alu; write_data_m = wd; write_reg_m = wr;
      for (int c = 0; c < 40; c++) begin
         mem_ack   = (c == k);
         mem_rdata = (c == k) ? rd : DW'($urandom);
         @(negedge clk);
         if (c == 0) begin req0 = mem_req; we0 = mem_we; end
         if (mem_req === 1'b1) begin
            reqs++;
            if (mem_addr !== alu || mem_wdata !== wd) stable = 0;
         end
         if (c > 0 && (valid_w !== 1'b0 || reg_write_w !== 1'b0 || pc_src_w !== 1'b0)) bub_ok = 0;
         done = (stall_mem !== 1'b1);
         if (!done) stalls++;
         @(posedge clk); #1;
         ncyc = c + 1;
         if (done) break;
      end
      valid_m = 0; mem_ack = 0; mem_write_m = 0; mem_to_reg_m = 0;
   endtask

   task automatic test_reset();
      rst = 1; valid_m = 1; mem_write_m = 0; mem_to_reg_m = 1; reg_write_m = 1; pc_src_m = 0;
      alu_result_m = 22'h123; write_data_m = 0; write_reg_m = 1; mem_ack = 0; mem_rdata = 0;
      #3;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", mem_req); end
      tests++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall_mem); end
      tests++; if ({valid_w, reg_write_w, mem_to_reg_w, pc_src_w, alu_result_w, read_data_w, write_reg_w, mem_error} !== '0)
         begin fails++; $display("FAIL reset_wout got nonzero W/error outputs want 0"); end
      @(posedge clk); #1;
      rst = 0; valid_m = 0; mem_to_reg_m = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      int s, r, n; bit st, bo; logic q0, w0;
      do_op(1, 1, 0, 0, 0, 22'h00ABC, 22'h0, 4'd3, -1, 22'h0, s, r, n, st, bo, q0, w0);
      tests++; if (s !== 0 || r !== 0) begin fails++; $display("FAIL alu_nostall stalls=%0d reqs=%0d want 0/0", s, r); end
      tests++; if (n !== 1) begin fails++; $display("FAIL alu_latency got %0d want 1", n); end
      tests++; if (valid_w !== 1'b1 || reg_write_w !== 1'b1) begin fails++; $display("FAIL alu_valid got %b%b want 11", valid_w, reg_write_w); end
      tests++; if (alu_result_w !== 22'h00ABC || write_reg_w !== 4'd3)
         begin fails++; $display("FAIL alu_data got %h/%0d want 00abc/3", alu_result_w, write_reg_w); end
   endtask

   task automatic test_zero_wait_load();
      int s, r, n; bit st, bo; logic q0, w0;
      do_op(1, 1, 0, 1, 0, 22'h10, 22'h0, 4'd5, 0, 22'h3FFFFF, s, r, n, st, bo, q0, w0);
      tests++; if (q0 !== 1'b1 || w0 !== 1'b0) begin fails++; $display("FAIL zw_req got req=%b we=%b want 1/0", q0, w0); end
      tests++; if (s !== 0 || n !== 1) begin fails++; $display("FAIL zw_stall stalls=%0d cyc=%0d want 0/1", s, n); end
      tests++; if (read_data_w !== 22'h3FFFFF || mem_to_reg_w !== 1'b1 || valid_w !== 1'b1)
         begin fails++; $display("FAIL zw_capture rd=%h m2r=%b v=%b want 3fffff/1/1", read_data_w, mem_to_reg_w, valid_w); end
   endtask

   task automatic test_wait_store();
      int s, r, n; bit st, bo; logic q0, w0;
      do_op(1, 0, 1, 0, 0, 22'h20, 22'h155, 4'd2, 3, 22'h2AAAA, s, r, n, st, bo, q0, w0);
      tests++; if (s !== 3 || n !== 4) begin fails++; $display("FAIL ws_stall stalls=%0d cyc=%0d want 3/4", s, n); end
      tests++; if (!st || r !== 4 || w0 !== 1'b1) begin fails++; $display("FAIL ws_req stable=%0d reqs=%0d we=%b want 1/4/1", st, r, w0); end
      tests++; if (!bo) begin fails++; $display("FAIL ws_bubble got non-bubble W during stall want bubble"); end
      tests++; if (valid_w !== 1'b1 || read_data_w !== 22'h0 || alu_result_w !== 22'h20)
         begin fails++; $display("FAIL ws_capture v=%b rd=%h alu=%h want 1/0/20", valid_w, read_data_w, alu_result_w); end
   endtask

   task automatic test_timeout();
      int s, r, n; bit st, bo; logic q0, w0;
      tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL to_err_before got %b want 0", mem_error); end
      do_op(1, 1, 0, 1, 0, 22'h44, 22'h0, 4'd7, -1, 22'h0, s, r, n, st, bo, q0, w0);
      tests++; if (s !== TO - 1 || n !== TO) begin fails++; $display("FAIL to_stall stalls=%0d cyc=%0d want %0d/%0d", s, n, TO - 1, TO); end
      tests++; if (valid_w !== 1'b1 || read_data_w !== 22'h0) begin fails++; $display("FAIL to_capture v=%b rd=%h want 1/0", valid_w, read_data_w); end
      tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL to_err got %b want 1", mem_error); end
      do_op(1, 1, 0, 0, 0, 22'h1, 22'h0, 4'd1, -1, 22'h0, s, r, n, st, bo, q0, w0);
      tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL to_err_sticky got %b want 1", mem_error); end
   endtask

   task automatic test_back_to_back();
      int s, r, n; bit st, bo; logic q0, w0;
      do_op(1, 1, 0, 1, 0, 22'h30, 22'h0, 4'd4, 1, 22'h0BEEF, s, r, n, st, bo, q0, w0);
      tests++; if (s !== 1 || valid_w !== 1'b1 || read_data_w !== 22'h0BEEF)
         begin fails++; $display("FAIL b2b_load stalls=%0d v=%b rd=%h want 1/1/0beef", s, valid_w, read_data_w); end
      do_op(1, 0, 1, 0, 0, 22'h34, 22'h77, 4'd0, 0, 22'h0, s, r, n, st, bo, q0, w0);
      tests++; if (q0 !== 1'b1 || w0 !== 1'b1 || s !== 0) begin fails++; $display("FAIL b2b_store_req req=%b we=%b stalls=%0d want 1/1/0", q0, w0, s); end
      tests++; if (valid_w !== 1'b1 || alu_result_w !== 22'h34 || read_data_w !== 22'h0)
         begin fails++; $display("FAIL b2b_store_cap v=%b alu=%h rd=%h want 1/34/0", valid_w, alu_result_w, read_data_w); end
      tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL b2b_err_sticky got %b want 1", mem_error); end
   endtask

   task automatic test_reset_busy();
      int s, r, n; bit st, bo; logic q0, w0;
      valid_m = 1; reg_write_m = 1; mem_write_m = 0; mem_to_reg_m = 1; pc_src_m = 0;
      alu_result_m = 22'h50; write_data_m = 0; write_reg_m = 4'd9; mem_ack = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++; if (mem_req !== 1'b1 || stall_mem !== 1'b1) begin fails++; $display("FAIL rb_busy req=%b stall=%b want 1/1", mem_req, stall_mem); end
      #2 rst = 1;
      #1;
      tests++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL rb_drop req=%b stall=%b want 0/0", mem_req, stall_mem); end
      tests++; if ({valid_w, reg_write_w, mem_to_reg_w, pc_src_w, alu_result_w, read_data_w, write_reg_w, mem_error} !== '0)
         begin fails++; $display("FAIL rb_wout got nonzero W/error outputs want 0"); end
      @(posedge clk); #1;
      rst = 0; valid_m = 0; mem_write_m = 0; mem_to_reg_m = 0; mem_ack = 1; mem_rdata = 22'h3ABCD;
      @(negedge clk);
      tests++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL rb_ack_ign req=%b stall=%b want 0/0", mem_req, stall_mem); end
      @(posedge clk); #1;
      mem_ack = 0;
      tests++; if (valid_w !== 1'b0 || read_data_w !== 22'h0) begin fails++; $display("FAIL rb_no_cap v=%b rd=%h want 0/0", valid_w, read_data_w); end
      do_op(1, 1, 0, 1, 0, 22'h58, 22'h0, 4'd2, 0, 22'h1234, s, r, n, st, bo, q0, w0);
      tests++; if (s !== 0 || n !== 1 || read_data_w !== 22'h1234 || mem_error !== 1'b0)
         begin fails++; $display("FAIL rb_idle stalls=%0d cyc=%0d rd=%h err=%b want 0/1/1234/0", s, n, read_data_w, mem_error); end
   endtask

   // Randomized run; model tracks the MEM/WB contents per instruction.
   task automatic test_random();
      int s, r, n; bit st, bo; logic q0, w0;
      logic v, rw, mw, m2r, pc; logic [DW-1:0] alu, wd, rd; logic [RW-1:0] wr; int k;
      logic e_v, e_rw, e_m2r, e_pc, e_err; logic [DW-1:0] e_alu, e_rd; logic [RW-1:0] e_wr;
      bit rd_known, memop, acked; int e_stall;
      e_v = 0; e_rw = 0; e_m2r = 0; e_pc = 0; e_alu = 0; e_rd = 0; e_wr = 0; e_err = 0; rd_known = 0;
      for (int i = 0; i < 60; i++) begin
         v = (i == 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
         rw = 1'($urandom); mw = 1'($urandom); m2r = 1'($urandom); pc = 1'($urandom);
         alu = DW'($urandom); wd = DW'($urandom); rd = DW'($urandom); wr = RW'($urandom);
         k = $urandom_range(0, TO + 1);
         memop = v && (mw || m2r);
         acked = memop && (k <= TO - 1);
         e_stall = memop ? ((k <= TO - 1) ? k : TO - 1) : 0;
         do_op(v, rw, mw, m2r, pc, alu, wd, wr, k, rd, s, r, n, st, bo, q0, w0);
         if (v) begin
            e_v = 1; e_rw = rw; e_m2r = m2r; e_pc = pc; e_alu = alu; e_wr = wr;
            e_rd = (acked && m2r && !mw) ? rd : '0;
            rd_known = memop;
            if (memop && !acked) e_err = 1;
         end else begin
            e_v = 0; e_rw = 0; e_pc = 0;
         end
         tests++; if (s !== e_stall || n !== e_stall + 1)
            begin fails++; $display("FAIL rnd_stall op%0d stalls=%0d cyc=%0d want %0d/%0d", i, s, n, e_stall, e_stall + 1); end
         tests++; if (r !== (memop ? e_stall + 1 : 0) || !st || !bo)
            begin fails++; $display("FAIL rnd_req op%0d reqs=%0d stable=%0d bub=%0d want %0d/1/1", i, r, st, bo, memop ? e_stall + 1 : 0); end
         if (memop) begin
            tests++; if (w0 !== mw) begin fails++; $display("FAIL rnd_we op%0d got %b want %b", i, w0, mw); end
         end
         tests++; if ({valid_w, reg_write_w, pc_src_w, mem_to_reg_w} !== {e_v, e_rw, e_pc, e_m2r})
            begin fails++; $display("FAIL rnd_ctl op%0d got %b%b%b%b want %b%b%b%b", i, valid_w, reg_write_w, pc_src_w, mem_to_reg_w, e_v, e_rw, e_pc, e_m2r); end
         tests++; if (alu_result_w !== e_alu || write_reg_w !== e_wr)
            begin fails++; $display("FAIL rnd_data op%0d got %h/%0d want %h/%0d", i, alu_result_w, write_reg_w, e_alu, e_wr); end
         if (rd_known) begin
            tests++; if (read_data_w !== e_rd) begin fails++; $display("FAIL rnd_rdata op%0d got %h want %h", i, read_data_w, e_rd); end
         end
         tests++; if (mem_error !== e_err) begin fails++; $display("FAIL rnd_err op%0d got %b want %b", i, mem_error, e_err); end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_zero_wait_load();
      test_wait_store();
      test_timeout();
      test_back_to_back();
      test_reset_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage that sits directly downstream of the execute stage and upstream of write-back. It consumes the execute result and control bits, performs load/store accesses to data memory over a req/ack handshake with variable latency, stalls the upstream pipeline while an access is outstanding, and registers the MEM/WB pipeline state. It also drives the forwarding value that execute selects with forward code 2.

## Interface
- DW, 22: datapath width
- RW, 4: register-index width
- TIMEOUT, 8: maximum cycles an access may wait for ack before abort (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_m  in  1  an instruction occupies MEM
- alu_result_m  in  DW  execute result; memory address for loads/stores
- write_data_m  in  DW  store data
- write_reg_m  in  RW  destination register
- reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m  in  1 each  control from execute
- mem_rdata  in  DW  read data, valid when mem_ack=1
- mem_ack  in  1  access complete this cycle
- mem_req  out  1  access request
- mem_we  out  1  1 = store, 0 = load
- mem_addr, mem_wdata  out  DW  address / store data
- alu_result_memory  out  DW  forwarding value (= alu_result_m, combinational)
- stall_mem  out  1  hold IF/ID/EX and MEM inputs this cycle
- valid_w, reg_write_w, mem_to_reg_w, pc_src_w  out  1 each  registered MEM/WB control
- alu_result_w, read_data_w  out  DW  registered MEM/WB data
- write_reg_w  out  RW  registered destination
- mem_error  out  1  sticky: an access timed out

## Operation
- Memory op = valid_m & (mem_write_m | mem_to_reg_m). Store takes priority if both set (mem_we=1).
- FSM states IDLE, BUSY; 8-bit-or-wider wait counter cnt.
- IDLE, no memory op: mem_req=0, stall_mem=0; MEM/WB captures inputs next edge.
- IDLE, memory op: mem_req=1, mem_addr=alu_result_m, mem_wdata=write_data_m. If mem_ack=1 same cycle: capture (read_data_w=mem_rdata for loads, 0 for stores), stall_mem=0, stay IDLE. Else stall_mem=1, go BUSY, cnt=1.
- BUSY: mem_req=1 with same address/data (upstream holds inputs while stalled). mem_ack=1 → capture, stall_mem=0, go IDLE. Else if cnt==TIMEOUT-1 → abort: capture with read_data_w=0, mem_error←1, stall_mem=0, go IDLE. Else stall_mem=1, cnt++.
- While stall_mem=1, MEM/WB loads a bubble: valid_w=0, reg_write_w=0, pc_src_w=0, other W fields hold.
- valid_m=0: bubble loaded into MEM/WB; no request.
- mem_ack while mem_req=0 is ignored.
- mem_error clears only on rst.
- mem_req, stall_mem forced 0 while rst=1.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, all W outputs 0, mem_error=0.
- Non-memory op and zero-wait access: latency 1 cycle MEM→W, no stall.
- Access acked on wait cycle k (k=0 same cycle): stall_mem high k cycles, W valid on edge ending cycle k.
- Timeout: stall_mem high TIMEOUT-1 cycles; op retires on edge ending cycle TIMEOUT-1 with mem_error rising then.
- Back-to-back memory ops: next op may request in the cycle after capture; no dead cycle.
- Reset during BUSY: request dropped immediately, no W capture, outstanding ack afterwards ignored.

## Test plan
- ALU op: valid_m=1, reg_write_m=1, alu_result_m=22'h00ABC, write_reg_m=3 -> next edge valid_w=1, alu_result_w=22'h00ABC, write_reg_w=3, stall_mem never 1.
- Zero-wait load: addr 22'h10, mem_ack=1 same cycle, mem_rdata=22'h3FFFFF -> mem_req=1, mem_we=0, stall_mem=0, next edge read_data_w=22'h3FFFFF, mem_to_reg_w=1.
- 3-wait store: addr 22'h20, data 22'h155, ack on cycle 3 -> stall_mem=1 cycles 0-2, mem_addr/mem_wdata stable, W bubble cycles 0-2 (reg_write_w=0), valid_w=1 after cycle 3.
- Timeout: TIMEOUT=8, load, no ack -> stall_mem=1 exactly 7 cycles, then read_data_w=0, mem_error=1 and stays 1 through later ops.
- Back-to-back: load (1 wait) then store (0 wait) -> store's mem_req asserted the cycle after load captures; two valid_w pulses, no lost op.
- Reset mid-BUSY on wait cycle 2 -> mem_req and stall_mem drop asynchronously, all W outputs 0, later mem_ack ignored, state IDLE.
